// File: rtl/scan_seq_139.sv
// rtl/scan_seq_139.sv - registered sequencer feeding both halves of a dual 2-to-4 decoder
module scan_seq_139 #(
    parameter int DWELL     = 4,
    parameter int GAP       = 1,
    parameter int PULSE_LEN = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SCAN_EN,
    input  logic [3:0] MASK,
    input  logic       REQ,
    input  logic [1:0] ADDR,
    output logic       G1,
    output logic       B1,
    output logic       A1,
    output logic       FRAME,
    output logic       G2,
    output logic       B2,
    output logic       A2,
    output logic       ACK,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam logic [7:0] GAP_M1   = 8'(GAP - 1);
    localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);

    typedef enum logic [1:0] {S1_IDLE, S1_BLANK, S1_DRIVE} s1_t;
    typedef enum logic [1:0] {S2_IDLE, S2_SETUP, S2_PULSE, S2_HOLD} s2_t;

    s1_t        s1_q, s1_d;
    logic [7:0] cnt1_q, cnt1_d;
    logic [1:0] slot_q, slot_d;
    logic [1:0] last_q, last_d;
    logic       pend_q, pend_d;
    logic       g1_q, g1_d;
    logic       frame_q, frame_d;

    s2_t        s2_q, s2_d;
    logic [7:0] cnt2_q, cnt2_d;
    logic [1:0] addr2_q, addr2_d;
    logic       g2_q, g2_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // First enabled slot after base, wrapping; base itself is the last candidate.
    function automatic logic [1:0] next_slot(input logic [3:0] m, input logic [1:0] base);
        logic [1:0] idx;
        next_slot = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (m[idx]) next_slot = idx;
        end
    endfunction

    always_comb begin
        logic [1:0] base;
        logic       do_load;
        s1_d    = s1_q;
        cnt1_d  = cnt1_q;
        slot_d  = slot_q;
        last_d  = last_q;
        pend_d  = pend_q;
        frame_d = 1'b0;
        base    = last_q;
        do_load = 1'b0;
        if (!SCAN_EN) begin
            s1_d   = S1_IDLE;
            pend_d = 1'b0;
        end else begin
            case (s1_q)
                S1_IDLE: begin
                    s1_d    = S1_BLANK;
                    base    = 2'd3;
                    last_d  = 2'd3;
                    do_load = 1'b1;
                end
                S1_BLANK: begin
                    if (pend_q) begin
                        do_load = 1'b1;
                    end else if (cnt1_q == 8'd0) begin
                        s1_d   = S1_DRIVE;
                        cnt1_d = DWELL_M1;
                    end else begin
                        cnt1_d = cnt1_q - 8'd1;
                    end
                end
                S1_DRIVE: begin
                    if (cnt1_q == 8'd0) begin
                        s1_d    = S1_BLANK;
                        do_load = 1'b1;
                    end else begin
                        cnt1_d = cnt1_q - 8'd1;
                    end
                end
                default: s1_d = S1_IDLE;
            endcase
        end
        // An empty mask parks the channel in BLANK and retries the load every cycle.
        if (do_load) begin
            if (MASK != 4'd0) begin
                slot_d  = next_slot(MASK, base);
                last_d  = slot_d;
                frame_d = (slot_d <= base);
                cnt1_d  = GAP_M1;
                pend_d  = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
        g1_d = (s1_d != S1_DRIVE);
    end

    always_comb begin
        s2_d    = s2_q;
        cnt2_d  = cnt2_q;
        addr2_d = addr2_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        case (s2_q)
            S2_IDLE: begin
                if (REQ) begin
                    s2_d    = S2_SETUP;
                    addr2_d = ADDR;
                    ack_d   = 1'b1;
                    // SETUP spans the ACK cycle plus one setup cycle: REQ to G2 fall is 2.
                    cnt2_d  = 8'd1;
                end
            end
            S2_SETUP: begin
                if (cnt2_q == 8'd0) begin
                    s2_d   = S2_PULSE;
                    cnt2_d = PULSE_M1;
                end else begin
                    cnt2_d = cnt2_q - 8'd1;
                end
            end
            S2_PULSE: begin
                if (cnt2_q == 8'd0) s2_d = S2_HOLD;
                else cnt2_d = cnt2_q - 8'd1;
            end
            S2_HOLD: begin
                s2_d   = S2_IDLE;
                done_d = 1'b1;
            end
            default: s2_d = S2_IDLE;
        endcase
        g2_d   = (s2_d != S2_PULSE);
        busy_d = (s2_d != S2_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_q    <= S1_IDLE;
            cnt1_q  <= 8'd0;
            slot_q  <= 2'd0;
            last_q  <= 2'd3;
            pend_q  <= 1'b0;
            g1_q    <= 1'b1;
            frame_q <= 1'b0;
            s2_q    <= S2_IDLE;
            cnt2_q  <= 8'd0;
            addr2_q <= 2'd0;
            g2_q    <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            cnt1_q  <= cnt1_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            g1_q    <= g1_d;
            frame_q <= frame_d;
            s2_q    <= s2_d;
            cnt2_q  <= cnt2_d;
            addr2_q <= addr2_d;
            g2_q    <= g2_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign G1    = g1_q;
    assign B1    = slot_q[1];
    assign A1    = slot_q[0];
    assign FRAME = frame_q;
    assign G2    = g2_q;
    assign B2    = addr2_q[1];
    assign A2    = addr2_q[0];
    assign ACK   = ack_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: doc/scan_seq_139.md
Name: scan_seq_139

Overview:
- Registered sequencer directly upstream of the dual 2-to-4 decoder; generates both halves' inputs (G1/B1/A1, G2/B2/A2).
- Channel 1 continuously scans decoder outputs 0..3 (display-digit / row scan) with programmable dwell, blanking dead-time and a slot mask.
- Channel 2 issues single request/acknowledge strobes on one selected output for a fixed pulse length.
- G is active-low, matching the decoder: G=1 drives all decoder outputs high.

Parameters:
- DWELL, 4, cycles G1 is held low per scanned slot; legal range 1..255.
- GAP, 1, blanking cycles (G1=1) before each slot, while B1/A1 change; legal range 1..255.
- PULSE_LEN, 2, cycles G2 is held low per channel-2 strobe; legal range 1..255.

Ports:
- CLK  input  1  single clock, all state on rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- SCAN_EN  input  1  1 = channel-1 scan runs.
- MASK  input  4  channel-1 slot enables, bit n = slot n.
- REQ  input  1  channel-2 strobe request.
- ADDR  input  2  channel-2 target output, {B2,A2}.
- G1, B1, A1  output  1 each  channel-1 decoder inputs.
- FRAME  output  1  one-cycle pulse when the scan wraps to its lowest enabled slot.
- G2, B2, A2  output  1 each  channel-2 decoder inputs.
- ACK  output  1  one-cycle pulse: REQ accepted.
- BUSY  output  1  channel 2 not idle.
- DONE  output  1  one-cycle pulse: strobe complete.

Behaviour:
- All outputs are registered.
- Reset (RST_N=0 at an edge): G1=G2=1, B1=A1=B2=A2=0, FRAME=ACK=BUSY=DONE=0, both FSMs go to IDLE, counters cleared.
- Reset mid-operation aborts immediately. Nothing resumes after reset.

Channel 1 FSM (IDLE, BLANK, DRIVE):
- IDLE: G1=1. SCAN_EN=1 -> BLANK, with internal last-slot preset to 3.
- Entering BLANK:
  - {B1,A1} loads the next slot: the first set MASK bit after last-slot, searching upward and wrapping 3->0. The search includes last-slot itself when it is the only set bit.
  - FRAME pulses if the new slot index is <= the previous one.
  - G1 stays 1 for GAP cycles.
- BLANK with MASK==0 at the load point:
  - {B1,A1} unchanged, G1=1.
  - Re-evaluate every cycle; then serve GAP before DRIVE.
- DRIVE: G1=0 for exactly DWELL cycles, then -> BLANK (next slot).
- Frame period with k enabled slots = k*(GAP+DWELL) cycles.
- MASK is sampled only at slot load. Changes during DRIVE take effect at the next slot.
- SCAN_EN=0 in any state:
  - Next edge -> IDLE, G1=1 (the current DRIVE is truncated).
  - B1/A1 hold.
  - Re-enable restarts from the lowest enabled slot.
- {B1,A1} never changes while G1=0.

Channel 2 FSM (IDLE, SETUP, PULSE, HOLD):
- IDLE: BUSY=0, G2=1. REQ=1 ->
  - latch ADDR into {B2,A2};
  - ACK=1 for one cycle;
  - -> SETUP, BUSY=1.
- SETUP: 1 cycle, G2=1 (address setup).
- PULSE: G2=0 for PULSE_LEN cycles.
- HOLD: 1 cycle, G2=1. DONE=1 is asserted on the same edge that returns to IDLE (BUSY=0).
- REQ while BUSY=1 is ignored (no ACK, no queueing).
- REQ held high restarts a new transaction on the cycle after return to IDLE.
- The REQ-to-G2-fall latency is 2 cycles.
- {B2,A2} is stable from SETUP through HOLD.
- Channels are fully independent. Simultaneous REQ and scan activity have no interaction.

Test Plan:
- Reset/defaults: hold RST_N=0 for 3 cycles with SCAN_EN=1, REQ=1 -> G1=G2=1, all other outputs 0; release -> activity starts on the next edges.
- Full scan: DWELL=4, GAP=1, MASK=1111, SCAN_EN=1 -> {B1,A1} steps 0,1,2,3,0; G1 is low for 4 of every 5 cycles; FRAME pulses every 20 cycles on the slot-0 load; address never changes while G1=0.
- Masked scan: MASK=0101 -> slots 0,2,0,2, 10-cycle frame. Switch MASK=0000 mid-DRIVE -> the current slot finishes, then G1 stays 1 until MASK=1000, after which slot 3 is driven.
- Scan abort: drop SCAN_EN 2 cycles into DRIVE -> G1=1 on the next edge; re-enable with MASK=0110 -> first slot 1, and FRAME pulses.
- Channel-2 strobe: PULSE_LEN=2, REQ with ADDR=2 -> ACK at edge 1, {B2,A2}=10, G2 low for edges 3-4, DONE with BUSY=0 at edge 6. A second REQ at edge 3 gets no ACK; REQ held high -> a new ACK at edge 7.
- Concurrency/reset mid-op: a strobe during an active scan leaves the scan timing unchanged; asserting RST_N=0 during PULSE -> G2=1, BUSY=0, and no DONE is emitted.
